// File: rtl/prm_edge_sched_if.sv
// Host-side handshakes of prm_edge_sched: the obstacle-code request and the collision-word stream.
// The block uses the slave modport; the host or planner uses master.
interface prm_edge_sched_if #(
    parameter int unsigned WORD_W = 32
);
    logic              code_valid;
    logic              code_ready;
    logic [14:0]       code;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;
    logic              out_last;
    logic              done;

    modport master (
        output code_valid, code, out_ready,
        input  code_ready, out_valid, out_data, out_last, done
    );

    modport slave (
        input  code_valid, code, out_ready,
        output code_ready, out_valid, out_data, out_last, done
    );
endinterface

// File: rtl/prm_edge_sched.sv
// PRM collision-sweep sequencer: issues every edge to the checker bank and packs results into words.
// Optional blocked-edge counter enabled by defining PRM_SCHED_BLKCNT_EN.
module prm_edge_sched #(
    parameter int unsigned NUM_EDGES = 256,
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned CHK_LAT   = 2,
    parameter int unsigned EW        = $clog2(NUM_EDGES)
) (
    input  logic            clk,
    input  logic            rst,
    prm_edge_sched_if.slave host,
    output logic            chk_valid,
    output logic [EW-1:0]   chk_sel,
    output logic [14:0]     chk_code,
    input  logic            chk_mask,
    output logic [EW:0]     blocked_cnt
);
    localparam int unsigned   PW       = $clog2(WORD_W);
    localparam logic [EW-1:0] LastEdge = EW'(NUM_EDGES - 1);
    localparam logic [PW-1:0] LastPos  = PW'(WORD_W - 1);

    typedef enum logic [1:0] {StIdle, StSweep, StDrain} state_e;
    state_e state_q, state_d;

    logic [EW-1:0] idx_q;
    logic [PW-1:0] iss_pos_q;
    logic [14:0]   code_q;
    logic [1:0]    open_q;
    logic          done_q;

    logic [CHK_LAT-1:0] pipe_vld_q;
    logic [CHK_LAT-1:0] pipe_eow_q;
    logic [CHK_LAT-1:0] pipe_last_q;
    logic [PW-1:0]      pipe_pos_q [CHK_LAT];
    logic [WORD_W-1:0]  acc_q;

    logic [WORD_W-1:0] fifo_data_q [2];
    logic [1:0]        fifo_last_q;
    logic              fifo_wr_q;
    logic              fifo_rd_q;
    logic [1:0]        fifo_cnt_q;

    logic              code_ready;
    logic              accept;
    logic              room;
    logic              last_issue;
    logic              open_inc;
    logic              cap_vld;
    logic              cap_eow;
    logic              cap_last;
    logic [PW-1:0]     cap_pos;
    logic [WORD_W-1:0] acc_ins;
    logic              push;
    logic              pop;
    logic              out_valid;
    logic              out_last;
    logic              last_pop;

    // A new word may only start if the FIFO plus words still being filled leave a free slot.
    assign room       = ({1'b0, fifo_cnt_q} + {1'b0, open_q}) < 3'd2;
    assign accept     = code_ready & host.code_valid;
    assign last_issue = chk_valid & (idx_q == LastEdge);
    assign open_inc   = chk_valid & (iss_pos_q == '0);

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (host.code_valid) state_d = StSweep;
            StSweep: if (last_issue) state_d = StDrain;
            StDrain: if (last_pop) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        code_ready = 1'b0;
        chk_valid  = 1'b0;
        unique case (state_q)
            StIdle:  code_ready = 1'b1;
            StSweep: chk_valid = (iss_pos_q != '0) | room;
            default: ;
        endcase
    end

    // Issue index, word position and latched obstacle code
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q     <= '0;
            iss_pos_q <= '0;
            code_q    <= '0;
        end else if (accept) begin
            idx_q     <= '0;
            iss_pos_q <= '0;
            code_q    <= host.code;
        end else if (chk_valid) begin
            if (!last_issue) idx_q <= idx_q + EW'(1);
            iss_pos_q <= (iss_pos_q == LastPos) ? '0 : iss_pos_q + PW'(1);
        end
    end

    // Delay line aligning issue metadata with the checker result
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_vld_q  <= '0;
            pipe_eow_q  <= '0;
            pipe_last_q <= '0;
            for (int k = 0; k < int'(CHK_LAT); k++) pipe_pos_q[k] <= '0;
        end else begin
            pipe_vld_q[0]  <= chk_valid;
            pipe_eow_q[0]  <= chk_valid & ((iss_pos_q == LastPos) | last_issue);
            pipe_last_q[0] <= last_issue;
            pipe_pos_q[0]  <= iss_pos_q;
            for (int k = 1; k < int'(CHK_LAT); k++) begin
                pipe_vld_q[k]  <= pipe_vld_q[k-1];
                pipe_eow_q[k]  <= pipe_eow_q[k-1];
                pipe_last_q[k] <= pipe_last_q[k-1];
                pipe_pos_q[k]  <= pipe_pos_q[k-1];
            end
        end
    end

    assign cap_vld  = pipe_vld_q[CHK_LAT-1];
    assign cap_eow  = pipe_eow_q[CHK_LAT-1];
    assign cap_last = pipe_last_q[CHK_LAT-1];
    assign cap_pos  = pipe_pos_q[CHK_LAT-1];
    assign acc_ins  = acc_q | (WORD_W'(chk_mask) << cap_pos);
    assign push     = cap_vld & cap_eow;

    // Accumulator restarts from zero so a partial final word has clean high bits
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else if (cap_vld) begin
            acc_q <= cap_eow ? '0 : acc_ins;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            open_q <= '0;
        end else if (open_inc && !push) begin
            open_q <= open_q + 2'd1;
        end else if (!open_inc && push) begin
            open_q <= open_q - 2'd1;
        end
    end

    // Two-entry fall-through output FIFO
    assign out_valid = (fifo_cnt_q != 2'd0);
    assign pop       = out_valid & host.out_ready;
    assign out_last  = out_valid & fifo_last_q[fifo_rd_q];
    assign last_pop  = pop & out_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_data_q[0] <= '0;
            fifo_data_q[1] <= '0;
            fifo_last_q    <= '0;
            fifo_wr_q      <= 1'b0;
            fifo_rd_q      <= 1'b0;
            fifo_cnt_q     <= '0;
        end else begin
            if (push) begin
                fifo_data_q[fifo_wr_q] <= acc_ins;
                fifo_last_q[fifo_wr_q] <= cap_last;
                fifo_wr_q              <= ~fifo_wr_q;
            end
            if (pop) fifo_rd_q <= ~fifo_rd_q;
            fifo_cnt_q <= fifo_cnt_q + 2'(push) - 2'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= last_pop;
        end
    end

`ifdef PRM_SCHED_BLKCNT_EN
    logic [EW:0] blk_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            blk_q <= '0;
        end else if (accept) begin
            blk_q <= '0;
        end else if (cap_vld && chk_mask) begin
            blk_q <= blk_q + (EW+1)'(1);
        end
    end

    assign blocked_cnt = blk_q;
`else
    assign blocked_cnt = '0;
`endif

    assign host.code_ready = code_ready;
    assign host.out_valid  = out_valid;
    assign host.out_data   = out_valid ? fifo_data_q[fifo_rd_q] : '0;
    assign host.out_last   = out_last;
    assign host.done       = done_q;
    assign chk_sel         = idx_q;
    assign chk_code        = code_q;

endmodule
